// File: rtl/mole_scheduler_if.sv
// Game-side signal bundle for mole_scheduler: PRNG word, tick, keys in; mole, score, status out.
interface mole_scheduler_if #(
   parameter int unsigned HOLE_W  = 3,
   parameter int unsigned SCORE_W = 8
);
   localparam int unsigned HOLES = 2 ** HOLE_W;

   logic [31:0]        random;
   logic               tick;
   logic               start;
   logic [1:0]         level;
   logic [HOLES-1:0]   hit;
   logic [HOLES-1:0]   mole;
   logic [SCORE_W-1:0] score;
   logic [SCORE_W-1:0] miss;
   logic               running;
   logic               game_over;
   logic               hit_ok;

   modport master (
      output random, tick, start, level, hit,
      input  mole, score, miss, running, game_over, hit_ok
   );

   modport slave (
      input  random, tick, start, level, hit,
      output mole, score, miss, running, game_over, hit_ok
   );
endinterface

// File: rtl/mole_scheduler.sv
// Whack-a-mole sequencer: picks a hole from the PRNG word, times each mole on the game tick,
// judges hits and keeps score/miss counts over a fixed number of rounds.
module mole_scheduler #(
   parameter int unsigned HOLE_W    = 3,
   parameter int unsigned GAP_TICKS = 250,
   parameter int unsigned UP_TICKS  = 800,
   parameter int unsigned ROUNDS    = 30,
   parameter int unsigned SCORE_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   mole_scheduler_if.slave   bus
);
   localparam int unsigned HOLES   = 2 ** HOLE_W;
   localparam int unsigned TMAX    = (GAP_TICKS > UP_TICKS) ? GAP_TICKS : UP_TICKS;
   localparam int unsigned TIMER_W = $clog2(TMAX + 1);

   localparam logic [TIMER_W-1:0] GAP_LD   = TIMER_W'(GAP_TICKS);
   localparam logic [TIMER_W-1:0] UP_LD    = TIMER_W'(UP_TICKS);
   localparam logic [TIMER_W-1:0] TIMER_1  = TIMER_W'(1);
   localparam logic [SCORE_W:0]   ROUNDS_C = (SCORE_W+1)'(ROUNDS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GAP  = 2'd1,
      S_UP   = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic [HOLE_W-1:0]   last_hole_q, last_hole_d;
   logic [SCORE_W-1:0]  round_q, round_d;
   logic [SCORE_W-1:0]  score_q, score_d;
   logic [SCORE_W-1:0]  miss_q, miss_d;
   logic [HOLES-1:0]    mole_q, mole_d;
   logic                running_q, running_d;
   logic                game_over_q, game_over_d;
   logic                hit_ok_q, hit_ok_d;

   logic [HOLE_W-1:0]   cand_c;
   logic [HOLE_W-1:0]   hole_c;
   logic [SCORE_W:0]    round_inc_c;
   logic                end_round_c;
   logic                unused_random_c;

   // Only the low bits of the PRNG word select the hole.
   assign unused_random_c = ^bus.random[31:HOLE_W];

   // Repeat avoidance: never raise the same hole twice in a row.
   assign cand_c      = bus.random[HOLE_W-1:0];
   assign hole_c      = (cand_c == last_hole_q) ? cand_c + HOLE_W'(1) : cand_c;
   assign round_inc_c = {1'b0, round_q} + (SCORE_W+1)'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         timer_q     <= '0;
         last_hole_q <= '0;
         round_q     <= '0;
         score_q     <= '0;
         miss_q      <= '0;
         mole_q      <= '0;
         running_q   <= 1'b0;
         game_over_q <= 1'b0;
         hit_ok_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         last_hole_q <= last_hole_d;
         round_q     <= round_d;
         score_q     <= score_d;
         miss_q      <= miss_d;
         mole_q      <= mole_d;
         running_q   <= running_d;
         game_over_q <= game_over_d;
         hit_ok_q    <= hit_ok_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      last_hole_d = last_hole_q;
      round_d     = round_q;
      score_d     = score_q;
      miss_d      = miss_q;
      mole_d      = mole_q;
      running_d   = running_q;
      game_over_d = game_over_q;
      hit_ok_d    = 1'b0;
      end_round_c = 1'b0;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            // A simultaneous tick is deliberately not counted against the fresh gap.
            if (bus.start) begin
               score_d     = '0;
               miss_d      = '0;
               round_d     = '0;
               last_hole_d = '0;
               timer_d     = GAP_LD;
               mole_d      = '0;
               running_d   = 1'b1;
               game_over_d = 1'b0;
               state_d     = S_GAP;
            end
         end

         S_GAP: begin
            if (bus.tick) begin
               if (timer_q == TIMER_1) begin
                  mole_d      = HOLES'(1) << hole_c;
                  last_hole_d = hole_c;
                  timer_d     = UP_LD >> bus.level;
                  state_d     = S_UP;
               end else begin
                  timer_d = timer_q - TIMER_1;
               end
            end
         end

         S_UP: begin
            // A correct hit beats an expiring tick in the same cycle.
            if ((bus.hit & mole_q) != '0) begin
               score_d     = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
               hit_ok_d    = 1'b1;
               end_round_c = 1'b1;
            end else if (bus.tick) begin
               if (timer_q == TIMER_1) begin
                  miss_d      = (miss_q == '1) ? miss_q : miss_q + SCORE_W'(1);
                  end_round_c = 1'b1;
               end else begin
                  timer_d = timer_q - TIMER_1;
               end
            end

            if (end_round_c) begin
               mole_d  = '0;
               round_d = round_inc_c[SCORE_W-1:0];
               if (round_inc_c == ROUNDS_C) begin
                  running_d   = 1'b0;
                  game_over_d = 1'b1;
                  state_d     = S_DONE;
               end else begin
                  timer_d = GAP_LD;
                  state_d = S_GAP;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign bus.mole      = mole_q;
   assign bus.score     = score_q;
   assign bus.miss      = miss_q;
   assign bus.running   = running_q;
   assign bus.game_over = game_over_q;
   assign bus.hit_ok    = hit_ok_q;
endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler with GAP_TICKS=2, UP_TICKS=8, ROUNDS=3 and a tick every cycle.
module tb_mole_scheduler;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   mole_scheduler_if #(.HOLE_W(3), .SCORE_W(8)) bus ();

   mole_scheduler #(
      .HOLE_W   (3),
      .GAP_TICKS(2),
      .UP_TICKS (8),
      .ROUNDS   (3),
      .SCORE_W  (8)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " mole"},      32'(bus.mole),      32'h0);
      chk({tag, " score"},     32'(bus.score),     32'h0);
      chk({tag, " miss"},      32'(bus.miss),      32'h0);
      chk({tag, " running"},   32'(bus.running),   32'h0);
      chk({tag, " game_over"}, 32'(bus.game_over), 32'h0);
      chk({tag, " hit_ok"},    32'(bus.hit_ok),    32'h0);
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.tick   = 1'b1;
      bus.level  = 2'd0;
      bus.random = 32'h5;
      bus.hit    = 8'h00;
      step();
      step();
      chk_all_zero("reset");
      rst_n = 1'b1;
      step();
      chk("idle running", 32'(bus.running), 32'h0);

      // Game 1: random=5, never hit; repeat avoidance gives 0x20, 0x40, 0x20.
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("g1 start running", 32'(bus.running), 32'h1);
      chk("g1 gap mole a", 32'(bus.mole), 32'h0);
      step();
      chk("g1 gap mole b", 32'(bus.mole), 32'h0);
      step();
      chk("g1 mole1", 32'(bus.mole), 32'h20);
      run(7);
      chk("g1 mole1 up8", 32'(bus.mole), 32'h20);
      chk("g1 miss before expiry", 32'(bus.miss), 32'h0);
      step();
      chk("g1 mole1 cleared", 32'(bus.mole), 32'h0);
      chk("g1 miss1", 32'(bus.miss), 32'h1);
      run(2);
      chk("g1 mole2 repeat avoided", 32'(bus.mole), 32'h40);
      run(7);
      chk("g1 mole2 up8", 32'(bus.mole), 32'h40);
      step();
      chk("g1 miss2", 32'(bus.miss), 32'h2);
      run(2);
      chk("g1 mole3", 32'(bus.mole), 32'h20);
      run(8);
      chk("g1 miss3", 32'(bus.miss), 32'h3);
      chk("g1 score", 32'(bus.score), 32'h0);
      chk("g1 game_over", 32'(bus.game_over), 32'h1);
      chk("g1 running off", 32'(bus.running), 32'h0);
      chk("g1 mole off", 32'(bus.mole), 32'h0);
      step();
      chk("g1 game_over held", 32'(bus.game_over), 32'h1);

      // Game 2: random=7 -> 0x80 then wrap to 0x01; hit, wrong hit, hit on expiring tick.
      bus.random = 32'h7;
      bus.start  = 1'b1;
      step();
      bus.start = 1'b0;
      chk("g2 restart running", 32'(bus.running), 32'h1);
      chk("g2 restart game_over", 32'(bus.game_over), 32'h0);
      chk("g2 restart miss cleared", 32'(bus.miss), 32'h0);
      run(2);
      chk("g2 mole1", 32'(bus.mole), 32'h80);
      run(2);
      chk("g2 mole1 up3", 32'(bus.mole), 32'h80);
      bus.hit = 8'h80;
      step();
      bus.hit = 8'h00;
      chk("g2 hit_ok", 32'(bus.hit_ok), 32'h1);
      chk("g2 score1", 32'(bus.score), 32'h1);
      chk("g2 mole cleared on hit", 32'(bus.mole), 32'h0);
      step();
      chk("g2 hit_ok one cycle", 32'(bus.hit_ok), 32'h0);
      chk("g2 gap mole", 32'(bus.mole), 32'h0);
      step();
      chk("g2 mole2 wrap", 32'(bus.mole), 32'h01);
      bus.hit = 8'h02;
      step();
      bus.hit = 8'h00;
      chk("g2 wrong hit mole", 32'(bus.mole), 32'h01);
      chk("g2 wrong hit hit_ok", 32'(bus.hit_ok), 32'h0);
      chk("g2 wrong hit score", 32'(bus.score), 32'h1);
      run(6);
      chk("g2 mole2 up8", 32'(bus.mole), 32'h01);
      bus.hit = 8'h01;
      step();
      bus.hit = 8'h00;
      chk("g2 hit on expiry hit_ok", 32'(bus.hit_ok), 32'h1);
      chk("g2 hit on expiry score", 32'(bus.score), 32'h2);
      chk("g2 hit on expiry miss", 32'(bus.miss), 32'h0);
      chk("g2 hit on expiry mole", 32'(bus.mole), 32'h0);
      run(2);
      chk("g2 mole3", 32'(bus.mole), 32'h80);
      chk("g2 score before reset", 32'(bus.score), 32'h2);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk_all_zero("midgame reset");

      // Game 3: level=3 -> one-tick moles; start during UP ignored; hits outside UP ignored.
      bus.level  = 2'd3;
      bus.random = 32'h5;
      bus.start  = 1'b1;
      step();
      bus.start = 1'b0;
      chk("g3 start running", 32'(bus.running), 32'h1);
      run(2);
      chk("g3 mole1", 32'(bus.mole), 32'h20);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("g3 mole1 one tick", 32'(bus.mole), 32'h0);
      chk("g3 start in UP ignored miss", 32'(bus.miss), 32'h1);
      chk("g3 start in UP running", 32'(bus.running), 32'h1);
      chk("g3 score", 32'(bus.score), 32'h0);
      step();
      chk("g3 gap mole", 32'(bus.mole), 32'h0);
      step();
      chk("g3 mole2", 32'(bus.mole), 32'h40);
      step();
      chk("g3 miss2", 32'(bus.miss), 32'h2);
      bus.hit = 8'hFF;
      step();
      bus.hit = 8'h00;
      chk("g3 gap hit hit_ok", 32'(bus.hit_ok), 32'h0);
      chk("g3 gap hit score", 32'(bus.score), 32'h0);
      chk("g3 gap hit mole", 32'(bus.mole), 32'h0);
      step();
      chk("g3 mole3", 32'(bus.mole), 32'h20);
      step();
      chk("g3 miss3", 32'(bus.miss), 32'h3);
      chk("g3 game_over", 32'(bus.game_over), 32'h1);
      chk("g3 running off", 32'(bus.running), 32'h0);
      bus.hit = 8'hFF;
      step();
      bus.hit = 8'h00;
      chk("g3 done hit hit_ok", 32'(bus.hit_ok), 32'h0);
      chk("g3 done hit score", 32'(bus.score), 32'h0);
      chk("g3 done game_over held", 32'(bus.game_over), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
